// File: rtl/if_stage.sv
// Instruction fetch stage: issues one-word fetch requests, waits for the
// instruction memory to return data, and loads the IF/ID pipeline register.
// Handles stalls through a one-entry hold buffer and drops fetches that a
// branch or jump redirect has made stale.
// Optional build macro: IF_PERF_COUNT_EN enables the stall/flush counters.
module if_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  op_code,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            req_q, req_d;

  logic            redirect_act;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc_inc;

  // Redirect decode: branch wins over jump, ignored while idle, word aligned
  always_comb begin
    redirect_act = (branch_taken | jump) && (state_q != IDLE);
    redirect_pc  = branch_taken ? branch_target : jump_target;
    redirect_pc[1:0] = 2'b00;
    pc_inc       = pc_q + XLEN'(4);
  end

  // Fetch FSM next-state, pc, hold buffer and IF/ID register updates
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    hold_d       = hold_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    case (state_q)
      IDLE: begin
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
        if (redirect_act) begin
          kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_act) begin
          if (imem_valid) begin
            kill_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ISSUE;
          end else if (stall) begin
            hold_d  = imem_data;
            state_d = HOLD;
          end else begin
            ifid_instr_d = imem_data;
            ifid_pc4_d   = pc_inc;
            ifid_valid_d = 1'b1;
            pc_d         = pc_inc;
            state_d      = ISSUE;
          end
        end
      end
      HOLD: begin
        if (redirect_act) begin
          hold_d  = '0;
          state_d = ISSUE;
        end else if (!stall) begin
          ifid_instr_d = hold_q;
          ifid_pc4_d   = pc_inc;
          ifid_valid_d = 1'b1;
          pc_d         = pc_inc;
          state_d      = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect overrides any pc advance and flushes IF/ID, even under stall
    if (redirect_act) begin
      pc_d         = redirect_pc;
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end

    req_d = (state_d == ISSUE);
  end

  // State and pipeline registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      kill_q       <= 1'b0;
      hold_q       <= '0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      hold_q       <= hold_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      req_q        <= req_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;
  assign op_code    = ifid_instr_q[31:26];

`ifdef IF_PERF_COUNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating stall-cycle and redirect counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (redirect_act && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = CNT_W'(0);
  assign flush_count  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the fetch stage.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  op_code;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  int total;
  int bad;

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_data     (imem_data),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .op_code       (op_code),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: a request is either about to go out, in flight
  // (possibly stale), or its data is parked waiting for the stall to clear.
  logic        m_starting;
  logic        m_issuing;
  logic        m_inflight;
  logic        m_stale;
  logic [31:0] m_park[$];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  int          m_stalls;
  int          m_flushes;

  task automatic model_reset();
    m_starting = 1'b1;
    m_issuing  = 1'b0;
    m_inflight = 1'b0;
    m_stale    = 1'b0;
    m_park.delete();
    m_pc       = 32'h0;
    m_instr    = 32'h0;
    m_pc4      = 32'h0;
    m_valid    = 1'b0;
    m_stalls   = 0;
    m_flushes  = 0;
  endtask

  task automatic model_accept(input logic [31:0] d);
    m_instr = d;
    m_pc4   = m_pc + 32'd4;
    m_pc    = m_pc + 32'd4;
    m_valid = 1'b1;
  endtask

  task automatic model_step();
    logic        redir;
    logic [31:0] tgt;
    if (!rst_n) begin
      model_reset();
    end else begin
      redir = (branch_taken || jump) && !m_starting;
      tgt   = branch_taken ? branch_target : jump_target;
      tgt   = tgt & 32'hFFFF_FFFC;
      if (stall && m_stalls < 65535) m_stalls++;
      if (redir && m_flushes < 65535) m_flushes++;
      if (redir) begin
        m_pc    = tgt;
        m_instr = 32'h0;
        m_valid = 1'b0;
      end
      if (m_starting) begin
        m_starting = 1'b0;
        m_issuing  = 1'b1;
      end else if (m_issuing) begin
        m_issuing  = 1'b0;
        m_inflight = 1'b1;
        m_stale    = redir;
      end else if (m_inflight) begin
        if (imem_valid) begin
          m_inflight = 1'b0;
          if (redir || m_stale) begin
            m_stale   = 1'b0;
            m_issuing = 1'b1;
          end else if (stall) begin
            m_park.push_back(imem_data);
          end else begin
            model_accept(imem_data);
            m_issuing = 1'b1;
          end
        end else if (redir) begin
          m_stale = 1'b1;
        end
      end else if (m_park.size() > 0) begin
        if (redir) begin
          m_park.delete();
          m_issuing = 1'b1;
        end else if (!stall) begin
          model_accept(m_park.pop_front());
          m_issuing = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    int es;
    int ef;
`ifdef IF_PERF_COUNT_EN
    es = m_stalls;
    ef = m_flushes;
`else
    es = 0;
    ef = 0;
`endif
    chk("imem_req",     32'(imem_req),     32'(m_issuing));
    chk("imem_addr",    imem_addr,         m_pc);
    chk("pc",           pc,                m_pc);
    chk("ifid_instr",   ifid_instr,        m_instr);
    chk("ifid_pc4",     ifid_pc4,          m_pc4);
    chk("ifid_valid",   32'(ifid_valid),   32'(m_valid));
    chk("op_code",      32'(op_code),      32'(m_instr[31:26]));
    chk("stall_cycles", 32'(stall_cycles), 32'(es));
    chk("flush_count",  32'(flush_count),  32'(ef));
  endtask

  // One clock: drive inputs at negedge, advance model at posedge, check after
  task automatic cyc(input logic s, input logic b, input logic [31:0] bt,
                     input logic jv, input logic [31:0] jt,
                     input logic v, input logic [31:0] d);
    @(negedge clk);
    stall         = s;
    branch_taken  = b;
    branch_target = bt;
    jump          = jv;
    jump_target   = jt;
    imem_valid    = v;
    imem_data     = d;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic ret(input logic s, input logic [31:0] d);
    cyc(s, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, d);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    jump = 1'b0;
    jump_target = 32'h0;
    imem_valid = 1'b0;
    imem_data = 32'h0;
    model_reset();

    // Reset state
    idle_cyc();
    idle_cyc();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);

    // Back-to-back fetches: addresses 0, 4, 8
    rst_n = 1'b1;
    idle_cyc();
    chk("seq_req0", 32'(imem_req), 32'h1);
    chk("seq_addr0", imem_addr, 32'h0);
    idle_cyc();
    ret(1'b0, 32'h8C01_0004);
    chk("seq_opcode", 32'(op_code), 32'h23);
    chk("seq_pc4", ifid_pc4, 32'h4);
    chk("seq_addr1", imem_addr, 32'h4);
    idle_cyc();
    ret(1'b0, 32'h8C01_0004);
    chk("seq_addr2", imem_addr, 32'h8);

    // Stall at data return parks it; release loads it and advances pc once
    idle_cyc();
    ret(1'b1, 32'h2042_0001);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hold_instr", ifid_instr, 32'h8C01_0004);
    chk("hold_pc", pc, 32'h8);
    idle_cyc();
    chk("rel_instr", ifid_instr, 32'h2042_0001);
    chk("rel_pc", pc, 32'hC);

    // Branch while waiting drops the returning data
    idle_cyc();
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    ret(1'b0, 32'hDEAD_BEEF);
    chk("br_valid", 32'(ifid_valid), 32'h0);
    chk("br_addr", imem_addr, 32'h40);

    // Branch beats jump
    cyc(1'b0, 1'b1, 32'h80, 1'b1, 32'h100, 1'b0, 32'h0);
    ret(1'b0, 32'hCAFE_F00D);
    chk("prio_addr", imem_addr, 32'h80);

    // Stall does not suppress the in-flight request; counter totals
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef IF_PERF_COUNT_EN
    chk("perf_stalls", 32'(stall_cycles), 32'd5);
    chk("perf_flushes", 32'(flush_count), 32'd2);
`else
    chk("perf_stalls", 32'(stall_cycles), 32'd0);
    chk("perf_flushes", 32'(flush_count), 32'd0);
`endif
    ret(1'b0, 32'h8C01_0004);
    chk("after_stall_pc4", ifid_pc4, 32'h84);

    // Unaligned jump target masked; pc wraps past 0xFFFFFFFC
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    ret(1'b0, 32'h1111_1111);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    idle_cyc();
    ret(1'b0, 32'h1234_5678);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc4", ifid_pc4, 32'h0);

    // Reset mid-fetch; returns in IDLE/ISSUE are ignored
    idle_cyc();
    rst_n = 1'b0;
    ret(1'b0, 32'hAAAA_AAAA);
    rst_n = 1'b1;
    ret(1'b0, 32'hBBBB_BBBB);
    ret(1'b0, 32'hCCCC_CCCC);
    chk("rst_ignore_valid", 32'(ifid_valid), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic s, b, jv, v;
      rst_n = ($urandom_range(0, 59) != 0);
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 11) == 0);
      jv = ($urandom_range(0, 11) == 0);
      v  = ($urandom_range(0, 1) == 0);
      cyc(s, b, $urandom, jv, $urandom, v, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
